multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM sequencing a shared-memory multi-cycle MIPS datapath (PC, IR, A/B, ALUOut, MDR regs).
//  Decodes IR opcode (R-type, LW, SW, BEQ, J, ADDI, ORI) and emits per-cycle mux selects and write enables.
//  Memory accesses stall on a ready handshake. Sits beside the datapath; the ALU decoder consumes alu_op.
// PARAMETERS
//  CNT_W  32  width of perf counters (used only with MC_PERF_CNT_EN)
// PORTS
//  clk          in   1   rising-edge clock, sole clock domain
//  reset        in   1   synchronous, active-high
//  opcode       in   6   IR[31:26], valid from DECODE onward
//  mem_ready    in   1   memory completes current read/write this cycle
//  pc_write     out  1   unconditional PC load
//  pc_write_cond out 1   PC load if ALU zero (BEQ)
//  i_or_d       out  1   0=PC addresses memory, 1=ALUOut
//  mem_read     out  1   memory read request
//  mem_write    out  1   memory write request
//  ir_write     out  1   load IR from memory data
//  mem_to_reg   out  1   regfile write data: 0=ALUOut, 1=MDR
//  reg_dst      out  1   dest: 0=rt, 1=rd
//  reg_write    out  1   regfile write enable
//  alu_src_a    out  1   0=PC, 1=A
//  alu_src_b    out  2   00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op       out  2   00=add, 01=sub, 10=funct decode, 11=OR (zero-ext imm)
//  pc_source    out  2   00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op   out  1   one-cycle pulse in DECODE on unknown opcode
//  instr_done   out  1   one-cycle pulse on last cycle of each instruction
// BEHAVIOUR
//  - States (4-bit): FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP, IMM_EXEC, IMM_WB.
//  - reset (sync, any state, including mid-memory-access): state<=FETCH next edge; all outputs Moore-decoded from state,
//    so in the reset cycle every output is 0 except FETCH values: mem_read=1, alu_src_b=01; pc_write/ir_write=0 until mem_ready.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00;
//    ir_write=pc_write=mem_ready (only qualified Mealy terms). Stay while !mem_ready; ->DECODE when mem_ready.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next: R->EXEC, LW/SW->MEM_ADDR,
//    BEQ->BRANCH, J->JUMP, ADDI/ORI->IMM_EXEC, other->FETCH with illegal_op=1 (no state write).
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; LW->MEM_RD, SW->MEM_WR.
//  - MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then ->MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
//  - MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready, then ->FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; ->R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH.
//  - JUMP: pc_write=1, pc_source=10; ->FETCH.
//  - IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 (ADDI) or 11 (ORI); ->IMM_WB.
//    IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
//  - opcode sampled only in DECODE/MEM_ADDR/IMM_EXEC (IR stable); instr_done=1 in MEM_WB, R_WB, BRANCH, JUMP, IMM_WB,
//    and in MEM_WR when mem_ready.
//  - Latency (zero wait): BEQ/J 3, R/SW/ADDI/ORI 4, LW 5 cycles; each memory wait adds exactly 1 cycle.
//  - mem_read and mem_write never both 1; mem_read/mem_write held stable until mem_ready.
// CONFIGURATION
//  - MC_PERF_CNT_EN defined: extra outputs cycle_cnt[CNT_W] (+1 every cycle out of reset) and instr_cnt[CNT_W]
//    (+1 per instr_done); both 0 on reset, wrap modulo 2^CNT_W, illegal opcodes not counted.
//  - Undefined: ports and counters absent; FSM behaviour identical.
// STRUCTURE
//  - mc_ctrl_pkg: opcode constants (R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000, ORI=001101),
//    state encodings, alu_op/alu_src_b/pc_source encodings.
//  - Sub-module mc_ctrl_decode: combinational state(+opcode, mem_ready) -> control word; top holds state reg + counters.
// TESTING
//  - reset held 2 cycles in MEM_RD -> next cycle state FETCH, mem_read=1, i_or_d=0, reg_write=0, counters 0.
//  - LW, mem_ready always 1 -> 5 cycles; reg_write=1 & mem_to_reg=1 in cycle 5 only; instr_done once.
//  - SW with mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, then FETCH; total 7 cycles.
//  - BEQ then J back-to-back -> pc_write_cond in cycle 3; pc_write=1 & pc_source=10 in cycle 6.
//  - ORI vs ADDI -> IMM_EXEC alu_op=11 vs 00; reg_dst=0 in IMM_WB; 4 cycles each.
//  - opcode 111111 -> illegal_op pulse in DECODE, FETCH next, no reg_write/mem_write; instr_cnt unchanged.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit.
//   Contents:
//     - instruction opcode constants (IR[31:26])
//     - FSM state encoding (4-bit enum)
//     - encodings for alu_op, alu_src_b and pc_source
//     - is_legal_op(): true for every opcode the controller sequences
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcodes recognised by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // Controller states; FETCH is the reset state
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC     = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_IMM_EXEC = 4'd10,
    ST_IMM_WB   = 4'd11
  } state_e;

  // ALU operation requested from the ALU decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  // ALU operand B select
  localparam logic [1:0] ALU_B_REG     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // True when the opcode belongs to the supported instruction subset
  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
//   Purely combinational decode of the controller state into the datapath
//   control word plus the next state. Outputs are Moore-decoded from the
//   state; the only input-qualified terms are the FETCH writes (ir_write,
//   pc_write), the DECODE illegal_op pulse, the IMM_EXEC ALU operation and
//   the MEM_WR completion pulse.
//   Ports:
//     state_i        current state (mc_ctrl_pkg::state_e encoding)
//     opcode_i       IR[31:26]
//     mem_ready_i    memory completes current access this cycle
//     next_state_o   state to load on the next clock edge
//     *_o            datapath control signals (see multicycle_control)
// ---------------------------------------------------------------------------
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic [3:0] next_state_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_op_o,
  output logic       instr_done_o
);

  state_e curState;
  state_e nextState;

  assign curState     = state_e'(state_i);
  assign next_state_o = nextState;

  // Control word and next state. Every output starts deasserted so each
  // state only lists what it drives; unused encodings fall back to FETCH.
  always_comb begin
    nextState       = ST_FETCH;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = ALU_B_REG;
    alu_op_o        = ALU_OP_ADD;
    pc_source_o     = PC_SRC_ALU;
    illegal_op_o    = 1'b0;
    instr_done_o    = 1'b0;

    case (curState)
      // PC+4 is computed every fetch cycle, but PC and IR only load once
      // the instruction word actually arrives.
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = ALU_B_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        nextState   = mem_ready_i ? ST_DECODE : ST_FETCH;
      end

      // Branch target is computed speculatively into ALUOut.
      ST_DECODE: begin
        alu_src_b_o = ALU_B_IMM_SH2;
        case (opcode_i)
          OP_RTYPE:        nextState = ST_EXEC;
          OP_LW, OP_SW:    nextState = ST_MEM_ADDR;
          OP_BEQ:          nextState = ST_BRANCH;
          OP_J:            nextState = ST_JUMP;
          OP_ADDI, OP_ORI: nextState = ST_IMM_EXEC;
          default: begin
            illegal_op_o = 1'b1;
            nextState    = ST_FETCH;
          end
        endcase
      end

      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALU_B_IMM;
        if (opcode_i == OP_LW) begin
          nextState = ST_MEM_RD;
        end else if (opcode_i == OP_SW) begin
          nextState = ST_MEM_WR;
        end else begin
          nextState = ST_FETCH;
        end
      end

      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        nextState  = mem_ready_i ? ST_MEM_WB : ST_MEM_RD;
      end

      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
        nextState    = ST_FETCH;
      end

      // A store finishes in the cycle the memory accepts it.
      ST_MEM_WR: begin
        mem_write_o  = 1'b1;
        i_or_d_o     = 1'b1;
        instr_done_o = mem_ready_i;
        nextState    = mem_ready_i ? ST_FETCH : ST_MEM_WR;
      end

      ST_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_FUNCT;
        nextState   = ST_R_WB;
      end

      ST_R_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
        nextState    = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_OP_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PC_SRC_ALUOUT;
        instr_done_o    = 1'b1;
        nextState       = ST_FETCH;
      end

      ST_JUMP: begin
        pc_write_o   = 1'b1;
        pc_source_o  = PC_SRC_JUMP;
        instr_done_o = 1'b1;
        nextState    = ST_FETCH;
      end

      // ORI zero-extends its immediate, so the ALU decoder needs a
      // distinct operation rather than a plain add.
      ST_IMM_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALU_B_IMM;
        alu_op_o    = (opcode_i == OP_ORI) ? ALU_OP_OR : ALU_OP_ADD;
        nextState   = ST_IMM_WB;
      end

      ST_IMM_WB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        nextState    = ST_FETCH;
      end

      default: begin
        nextState = ST_FETCH;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Moore FSM sequencing a shared-memory multi-cycle MIPS datapath. Holds the
//   state register (and optional performance counters); the control word is
//   produced by mc_ctrl_decode.
//   Configuration macro: MC_PERF_CNT_EN
//     defined   -> parameter CNT_W and outputs cycle_cnt / instr_cnt exist
//     undefined -> no counters, identical FSM behaviour
//   Ports:
//     clk, reset      clock; synchronous active-high reset
//     opcode          IR[31:26], valid from DECODE onward
//     mem_ready       memory completes current read/write this cycle
//     pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
//     pc_source       datapath controls
//     illegal_op      one-cycle pulse in DECODE on unknown opcode
//     instr_done      one-cycle pulse on last cycle of each instruction
//     cycle_cnt       cycles since reset          (MC_PERF_CNT_EN only)
//     instr_cnt       completed instructions      (MC_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module multicycle_control
  import mc_ctrl_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       instr_done
`ifdef MC_PERF_CNT_EN
 ,output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  state_e     state_q;
  logic [3:0] state_d;
  logic [3:0] decodeState;
  logic       decodeReady;

  // While reset is asserted the outputs already show the idle FETCH word,
  // and the memory handshake is masked so no PC/IR write can slip through
  // from whatever state was interrupted.
  assign decodeState = reset ? ST_FETCH : state_q;
  assign decodeReady = mem_ready & ~reset;

  mc_ctrl_decode uDecode (
    .state_i         (decodeState),
    .opcode_i        (opcode),
    .mem_ready_i     (decodeReady),
    .next_state_o    (state_d),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .i_or_d_o        (i_or_d),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .pc_source_o     (pc_source),
    .illegal_op_o    (illegal_op),
    .instr_done_o    (instr_done)
  );

  // State register; reset returns to FETCH from any state, including one
  // stalled mid-way through a memory access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_e'(state_d);
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycleCnt_q;
  logic [CNT_W-1:0] instrCnt_q;

  // Free-running counters that wrap naturally. Illegal opcodes never raise
  // instr_done, so they are excluded from the instruction count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycleCnt_q <= '0;
      instrCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_q + 1'b1;
      if (instr_done) begin
        instrCnt_q <= instrCnt_q + 1'b1;
      end
    end
  end

  assign cycle_cnt = cycleCnt_q;
  assign instr_cnt = instrCnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed-vector bench for multicycle_control. Each stimulus cycle pushes
//   the hand-computed control word it expects onto a scoreboard queue; a
//   monitor on the falling edge pops and compares against the DUT outputs.
//   Control word layout (MSB..LSB):
//     pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg
//     reg_dst reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source[1:0]
//     illegal_op instr_done
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  function automatic logic [17:0] cw(
    input logic pcw, input logic pcc, input logic iod, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rd,
    input logic rw, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] pcs, input logic ill,
    input logic done);
    return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill, done};
  endfunction

  //                                       pcw pcc iod mr mw irw m2r rd rw asa asb    aop    pcs    ill done
  localparam logic [17:0] E_FWAIT  = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
  localparam logic [17:0] E_FGO    = cw(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
  localparam logic [17:0] E_DEC    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
  localparam logic [17:0] E_DECILL = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
  localparam logic [17:0] E_MADDR  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
  localparam logic [17:0] E_MRD    = cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
  localparam logic [17:0] E_MWB    = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
  localparam logic [17:0] E_MWRW   = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
  localparam logic [17:0] E_MWRGO  = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
  localparam logic [17:0] E_EXEC   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
  localparam logic [17:0] E_RWB    = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
  localparam logic [17:0] E_BRANCH = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1);
  localparam logic [17:0] E_JUMP   = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 1);
  localparam logic [17:0] E_IMMADD = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
  localparam logic [17:0] E_IMMOR  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 2'b00, 0, 0);
  localparam logic [17:0] E_IMMWB  = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);

  logic       clk = 1'b1;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
  logic [31:0] expCycle, expInstr;
  logic        modelValid = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .instr_done    (instr_done)
`ifdef MC_PERF_CNT_EN
   ,.cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt)
`endif
  );

  logic [17:0] observed;
  assign observed = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, illegal_op, instr_done};

  typedef struct {
    logic [17:0] word;
    logic        rst;
    string       tag;
  } item_t;

  item_t sb[$];
  item_t monItem;
  int    total = 0;
  int    bad   = 0;

  // Drive one cycle of inputs and record what the outputs must be in it
  task automatic applyStimulus(input logic rst, input logic [5:0] op,
                               input logic rdy, input logic [17:0] exp,
                               input string tag);
    item_t it;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    it.word   = exp;
    it.rst    = rst;
    it.tag    = tag;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Compare one scoreboard entry against the live DUT outputs
  task automatic checkOutput(input item_t it);
    total++;
    if (observed !== it.word) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", it.tag, observed, it.word);
    end
    if (mem_read === 1'b1 && mem_write === 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_rdwr_excl: mem_read and mem_write both 1", it.tag);
    end
`ifdef MC_PERF_CNT_EN
    if (modelValid) begin
      total++;
      if (cycle_cnt !== expCycle || instr_cnt !== expInstr) begin
        bad++;
        $display("[TB] FAIL %s_cnt: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                 it.tag, cycle_cnt, instr_cnt, expCycle, expInstr);
      end
    end
    if (it.rst) begin
      expCycle   = '0;
      expInstr   = '0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      expCycle = expCycle + 1;
      expInstr = expInstr + {31'd0, it.word[0]};
    end
`endif
  endtask

  // Monitor: the control word is presented every cycle, so check mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      monItem = sb.pop_front();
      checkOutput(monItem);
    end
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset = 1'b1; opcode = OP_R; mem_ready = 1'b0;
    $display("[TB] starting multicycle_control directed test");

    applyStimulus(1, OP_R, 0, E_FWAIT, "rst0");
    applyStimulus(1, OP_R, 0, E_FWAIT, "rst1");

    // LW, one fetch wait then zero-wait access: 5 cycles after the wait
    applyStimulus(0, OP_LW, 0, E_FWAIT, "lw_fwait");
    applyStimulus(0, OP_LW, 1, E_FGO,   "lw_fetch");
    applyStimulus(0, OP_LW, 1, E_DEC,   "lw_dec");
    applyStimulus(0, OP_LW, 1, E_MADDR, "lw_addr");
    applyStimulus(0, OP_LW, 1, E_MRD,   "lw_rd");
    applyStimulus(0, OP_LW, 1, E_MWB,   "lw_wb");

    // LW with one read wait
    applyStimulus(0, OP_LW, 1, E_FGO,   "lw2_fetch");
    applyStimulus(0, OP_LW, 1, E_DEC,   "lw2_dec");
    applyStimulus(0, OP_LW, 1, E_MADDR, "lw2_addr");
    applyStimulus(0, OP_LW, 0, E_MRD,   "lw2_rdwait");
    applyStimulus(0, OP_LW, 1, E_MRD,   "lw2_rd");
    applyStimulus(0, OP_LW, 1, E_MWB,   "lw2_wb");

    // SW with three write waits: 7 cycles, mem_write held 4
    applyStimulus(0, OP_SW, 1, E_FGO,   "sw_fetch");
    applyStimulus(0, OP_SW, 1, E_DEC,   "sw_dec");
    applyStimulus(0, OP_SW, 1, E_MADDR, "sw_addr");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, OP_SW, 0, E_MWRW, $sformatf("sw_wait%0d", i));
    end
    applyStimulus(0, OP_SW, 1, E_MWRGO, "sw_wr");

    // BEQ then J back-to-back
    applyStimulus(0, OP_BEQ, 1, E_FGO,    "beq_fetch");
    applyStimulus(0, OP_BEQ, 1, E_DEC,    "beq_dec");
    applyStimulus(0, OP_BEQ, 1, E_BRANCH, "beq_br");
    applyStimulus(0, OP_J,   1, E_FGO,    "j_fetch");
    applyStimulus(0, OP_J,   1, E_DEC,    "j_dec");
    applyStimulus(0, OP_J,   1, E_JUMP,   "j_jump");

    // ORI vs ADDI
    applyStimulus(0, OP_ORI,  1, E_FGO,    "ori_fetch");
    applyStimulus(0, OP_ORI,  1, E_DEC,    "ori_dec");
    applyStimulus(0, OP_ORI,  1, E_IMMOR,  "ori_exec");
    applyStimulus(0, OP_ORI,  1, E_IMMWB,  "ori_wb");
    applyStimulus(0, OP_ADDI, 1, E_FGO,    "addi_fetch");
    applyStimulus(0, OP_ADDI, 1, E_DEC,    "addi_dec");
    applyStimulus(0, OP_ADDI, 1, E_IMMADD, "addi_exec");
    applyStimulus(0, OP_ADDI, 1, E_IMMWB,  "addi_wb");

    // R-type
    applyStimulus(0, OP_R, 1, E_FGO,  "r_fetch");
    applyStimulus(0, OP_R, 1, E_DEC,  "r_dec");
    applyStimulus(0, OP_R, 1, E_EXEC, "r_exec");
    applyStimulus(0, OP_R, 1, E_RWB,  "r_wb");

    // Illegal opcode returns straight to FETCH
    applyStimulus(0, OP_BAD, 1, E_FGO,    "ill_fetch");
    applyStimulus(0, OP_BAD, 1, E_DECILL, "ill_dec");
    applyStimulus(0, OP_BAD, 0, E_FWAIT,  "ill_after");

    // Reset held two cycles while stalled in MEM_RD
    applyStimulus(0, OP_LW, 1, E_FGO,   "rlw_fetch");
    applyStimulus(0, OP_LW, 1, E_DEC,   "rlw_dec");
    applyStimulus(0, OP_LW, 1, E_MADDR, "rlw_addr");
    applyStimulus(0, OP_LW, 0, E_MRD,   "rlw_rdwait");
    applyStimulus(1, OP_LW, 0, E_FWAIT, "rlw_rst0");
    applyStimulus(1, OP_LW, 1, E_FWAIT, "rlw_rst1");
    applyStimulus(0, OP_LW, 0, E_FWAIT, "rlw_after");

    // One more instruction after the mid-access reset
    applyStimulus(0, OP_J, 1, E_FGO,  "j2_fetch");
    applyStimulus(0, OP_J, 1, E_DEC,  "j2_dec");
    applyStimulus(0, OP_J, 1, E_JUMP, "j2_jump");
    applyStimulus(0, OP_R, 0, E_FWAIT, "final_idle");

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
